// File: rtl/vc_test_delay_pkg.sv
// ============================================================================
// Module : vc_test_delay_pkg
// Desc   : Shared types, LFSR constants and seed helpers for the test delay element
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vc_test_delay_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    FIXED  = 2'd1,
    RANDOM = 2'd2,
    BURST  = 2'd3
  } mode_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DELAY = 1'b1
  } chan_state_e;

  localparam logic [31:0] c_LFSR_TAPS   = 32'h8020_0003;
  localparam logic [31:0] c_SEED_SPREAD = 32'h9E37_79B9;

  // Spreads the base seed per channel; an all-zero LFSR would lock up, so map it to 1.
  function automatic logic [31:0] chan_seed(input logic [31:0] base, input int unsigned idx);
    logic [31:0] s;
    s = base ^ (idx * c_SEED_SPREAD);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ c_LFSR_TAPS) : (x >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vc_test_delay_chan.sv
// ============================================================================
// Module : vc_test_delay_chan
// Desc   : One channel of the delay element: LFSR, delay draw, FSM and counters
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vc_test_delay_chan
  import vc_test_delay_pkg::*;
#(
  parameter int unsigned p_msg_nbits = 32,
  parameter logic [31:0] p_seed      = 32'hACE1_2024,
  parameter int unsigned p_chan_idx  = 0,
  parameter int unsigned p_burst_len = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            max_delay,
  input  logic [1:0]             mode,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_msg_nbits-1:0] in_msg,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [p_msg_nbits-1:0] out_msg,
  output logic [31:0]            xfer_count
);

  localparam logic [31:0] c_SEED = chan_seed(p_seed, p_chan_idx);

  chan_state_e r_state;
  chan_state_e w_state_next;
  logic [31:0] r_lfsr;
  logic [31:0] r_ctr;
  logic [31:0] w_ctr_next;
  logic [31:0] r_burst_cnt;
  logic [31:0] w_burst_next;
  logic [31:0] r_xfer_count;
  logic        r_pend_zero;
  logic        w_pend_zero_next;
  logic        r_pend_gap;
  logic        w_pend_gap_next;

  mode_e       w_mode;
  logic [32:0] w_modulus;
  logic [31:0] w_rand;
  logic [31:0] w_draw;
  logic        w_draw_gap;
  logic        w_draw_zero_burst;
  logic        w_val;
  logic        w_rdy;
  logic        w_fire;

  assign w_mode    = mode_e'(mode);
  // 33-bit modulus so max_delay = 32'hFFFFFFFF still yields the full inclusive range.
  assign w_modulus = {1'b0, max_delay} + 33'd1;
  assign w_rand    = 32'({1'b0, r_lfsr} % w_modulus);

  always_comb begin
    w_draw            = 32'd0;
    w_draw_gap        = 1'b0;
    w_draw_zero_burst = 1'b0;
    case (w_mode)
      BYPASS: w_draw = 32'd0;
      FIXED:  w_draw = max_delay;
      RANDOM: w_draw = (max_delay == 32'd0) ? 32'd0 : w_rand;
      BURST: begin
        if (r_burst_cnt < 32'(p_burst_len)) begin
          w_draw_zero_burst = 1'b1;
        end else begin
          w_draw     = max_delay;
          w_draw_gap = 1'b1;
        end
      end
      default: w_draw = 32'd0;
    endcase
  end

  always_comb begin
    w_state_next     = r_state;
    w_ctr_next       = r_ctr;
    w_burst_next     = r_burst_cnt;
    w_pend_zero_next = r_pend_zero;
    w_pend_gap_next  = r_pend_gap;
    w_val            = 1'b0;
    w_rdy            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_val = in_val && (w_draw == 32'd0);
        w_rdy = out_rdy && (w_draw == 32'd0);
        if (in_val) begin
          if (w_mode != BURST) begin
            w_burst_next = 32'd0;
          end
          if (w_val && out_rdy) begin
            if (w_draw_zero_burst) begin
              w_burst_next = r_burst_cnt + 32'd1;
            end else if (w_draw_gap) begin
              w_burst_next = 32'd0;
            end
          end else begin
            // A zero draw that cannot fire parks in DELAY with ctr=0, so it is never redrawn.
            w_state_next     = ST_DELAY;
            w_ctr_next       = (w_draw == 32'd0) ? 32'd0 : w_draw - 32'd1;
            w_pend_zero_next = w_draw_zero_burst;
            w_pend_gap_next  = w_draw_gap;
          end
        end
      end
      ST_DELAY: begin
        w_val = in_val && (r_ctr == 32'd0);
        w_rdy = out_rdy && (r_ctr == 32'd0);
        if (r_ctr != 32'd0) begin
          w_ctr_next = r_ctr - 32'd1;
        end
        if (w_val && out_rdy) begin
          w_state_next = ST_IDLE;
          if (r_pend_zero) begin
            w_burst_next = r_burst_cnt + 32'd1;
          end else if (r_pend_gap) begin
            w_burst_next = 32'd0;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_fire = w_val && out_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ctr        <= 32'd0;
      r_burst_cnt  <= 32'd0;
      r_xfer_count <= 32'd0;
      r_lfsr       <= c_SEED;
      r_pend_zero  <= 1'b0;
      r_pend_gap   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ctr       <= w_ctr_next;
      r_burst_cnt <= w_burst_next;
      r_lfsr      <= lfsr_next(r_lfsr);
      r_pend_zero <= w_pend_zero_next;
      r_pend_gap  <= w_pend_gap_next;
      if (w_fire) begin
        r_xfer_count <= r_xfer_count + 32'd1;
      end
    end
  end

  assign out_val    = w_val & ~reset;
  assign in_rdy     = w_rdy & ~reset;
  assign out_msg    = out_val ? in_msg : '0;
  assign xfer_count = r_xfer_count;

  a_no_x: assert property (@(posedge clk) disable iff (reset)
    !$isunknown({max_delay, mode, in_val, out_rdy, in_rdy, out_val}));

  // Source must hold its message until accepted; the delay counter keeps running regardless.
  a_val_held: assert property (@(posedge clk) disable iff (reset)
    (r_state == ST_DELAY) |-> in_val);

endmodule

`default_nettype wire

// File: rtl/vc_test_rand_delay_nch.sv
// ============================================================================
// Module : vc_test_rand_delay_nch
// Desc   : Multi-channel, mode-selectable valid/ready delay element for test harnesses
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vc_test_rand_delay_nch
  import vc_test_delay_pkg::*;
#(
  parameter int unsigned p_msg_nbits = 32,
  parameter int unsigned p_nchannels = 2,
  parameter logic [31:0] p_seed      = 32'hACE1_2024,
  parameter int unsigned p_burst_len = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [31:0]                        max_delay,
  input  logic [1:0]                         mode,
  input  logic [p_nchannels-1:0]             in_val,
  output logic [p_nchannels-1:0]             in_rdy,
  input  logic [p_nchannels*p_msg_nbits-1:0] in_msg,
  output logic [p_nchannels-1:0]             out_val,
  input  logic [p_nchannels-1:0]             out_rdy,
  output logic [p_nchannels*p_msg_nbits-1:0] out_msg,
  output logic [p_nchannels*32-1:0]          xfer_count
);

  for (genvar i = 0; i < int'(p_nchannels); i++) begin : g_chan
    vc_test_delay_chan #(
      .p_msg_nbits (p_msg_nbits),
      .p_seed      (p_seed),
      .p_chan_idx  (i),
      .p_burst_len (p_burst_len)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .max_delay  (max_delay),
      .mode       (mode),
      .in_val     (in_val[i]),
      .in_rdy     (in_rdy[i]),
      .in_msg     (in_msg[i*p_msg_nbits +: p_msg_nbits]),
      .out_val    (out_val[i]),
      .out_rdy    (out_rdy[i]),
      .out_msg    (out_msg[i*p_msg_nbits +: p_msg_nbits]),
      .xfer_count (xfer_count[i*32 +: 32])
    );
  end

endmodule

`default_nettype wire
